// File: rtl/image_scale_param_buffer_pkg.sv
// Shared definitions for the image scale parameter buffer.
// The packing constants keep this block and the conv scale multiplier in
// agreement on the layout of one channel group.
package image_scale_param_buffer_pkg;

  localparam int WIDTH_DATA_ADD          = 32;
  localparam int COMPUTE_CHANNEL_OUT_NUM = 8;
  localparam int WIDTH_STREAM            = 64;
  localparam int WIDTH_GROUP_ADDR        = 6;

  // One channel group as presented on the multiplier's scale_data_in.
  localparam int IMAGE_BIAS_WIDTH_DATA = WIDTH_DATA_ADD * COMPUTE_CHANNEL_OUT_NUM;

  localparam int WORDS_PER_BEAT  = WIDTH_STREAM / WIDTH_DATA_ADD;
  localparam int BEATS_PER_GROUP = COMPUTE_CHANNEL_OUT_NUM / WORDS_PER_BEAT;
  localparam int WIDTH_BEAT_CNT  = $clog2(BEATS_PER_GROUP);
  localparam int GROUP_DEPTH     = 2 ** WIDTH_GROUP_ADDR;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_e;

endpackage

// File: rtl/image_scale_ram.sv
// Simple dual-port group RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle returns the old word.
// Ports:
//   clk, rst          clock, synchronous active-low reset (read register only)
//   wr_en/addr/data   write port, one full group per write
//   rd_en/addr        read request, sampled on the rising edge
//   rd_data           registered read data, holds when rd_en is low
module image_scale_ram
  import image_scale_param_buffer_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [WIDTH_GROUP_ADDR-1:0]      wr_addr,
  input  logic [IMAGE_BIAS_WIDTH_DATA-1:0] wr_data,
  input  logic                             rd_en,
  input  logic [WIDTH_GROUP_ADDR-1:0]      rd_addr,
  output logic [IMAGE_BIAS_WIDTH_DATA-1:0] rd_data
);

  logic [IMAGE_BIAS_WIDTH_DATA-1:0] mem [GROUP_DEPTH];

  // NOTE: the storage array has no reset so it maps onto block RAM; only the
  // output register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Both ports update with non-blocking assignments, so a same-address read
  // sees the contents from before this edge's write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/image_scale_param_buffer.sv
// Collects per-output-channel scale coefficients from the parameter stream,
// assembles them into channel groups and stores each group in a RAM; groups
// are read back one per request for the conv scale multiplier.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   load_start, load_groups  start a load of load_groups groups (IDLE only)
//   S_Data/S_Valid/S_Ready   parameter stream, two coefficients per beat
//   load_done                one-cycle pulse after the last group write
//   busy                     load in progress
//   scale_rd_en/group        read request for one group
//   scale_data/_valid        requested group, one cycle after the request
module image_scale_param_buffer
  import image_scale_param_buffer_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load_start,
  input  logic [WIDTH_GROUP_ADDR:0]        load_groups,
  input  logic [WIDTH_STREAM-1:0]          S_Data,
  input  logic                             S_Valid,
  output logic                             S_Ready,
  output logic                             load_done,
  output logic                             busy,
  input  logic                             scale_rd_en,
  input  logic [WIDTH_GROUP_ADDR-1:0]      scale_rd_group,
  output logic [IMAGE_BIAS_WIDTH_DATA-1:0] scale_data,
  output logic                             scale_data_valid
);

  localparam logic [WIDTH_BEAT_CNT-1:0]   LAST_BEAT = WIDTH_BEAT_CNT'(BEATS_PER_GROUP - 1);
  localparam logic [WIDTH_BEAT_CNT-1:0]   BEAT_ONE  = WIDTH_BEAT_CNT'(1);
  localparam logic [WIDTH_GROUP_ADDR:0]   GROUP_ONE = (WIDTH_GROUP_ADDR + 1)'(1);

  load_state_e                      state_q, state_d;
  logic [WIDTH_GROUP_ADDR:0]        groups_q;
  logic [WIDTH_GROUP_ADDR:0]        grp_cnt_q;
  logic [WIDTH_BEAT_CNT-1:0]        beat_cnt_q;
  logic [IMAGE_BIAS_WIDTH_DATA-1:0] asm_q;
  logic [IMAGE_BIAS_WIDTH_DATA-1:0] wr_data;
  logic                             beat_fire;
  logic                             last_beat;
  logic                             last_group;
  logic                             wr_en;
  logic                             rd_valid_q;

  assign beat_fire  = (state_q == LOAD) && S_Valid;
  assign last_beat  = (beat_cnt_q == LAST_BEAT);
  assign last_group = (grp_cnt_q == groups_q - GROUP_ONE);
  // Gating with rst drops a group whose last beat coincides with reset.
  assign wr_en      = beat_fire && last_beat && rst;

  // The last beat of a group fills the top word pair, so the written group is
  // the assembled lower words with the live beat spliced on top.
  always_comb begin
    wr_data = asm_q;
    wr_data[IMAGE_BIAS_WIDTH_DATA-1 -: WIDTH_STREAM] = S_Data;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (load_start) state_d = (load_groups != '0) ? LOAD : DONE;
      end
      LOAD: begin
        if (beat_fire && last_beat && last_group) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      groups_q   <= '0;
      grp_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && load_start) begin
        groups_q   <= load_groups;
        grp_cnt_q  <= '0;
        beat_cnt_q <= '0;
      end else if (beat_fire) begin
        if (last_beat) begin
          beat_cnt_q <= '0;
          grp_cnt_q  <= grp_cnt_q + GROUP_ONE;
        end else begin
          beat_cnt_q <= beat_cnt_q + BEAT_ONE;
        end
      end
    end
  end

  // Assembly register needs no reset: each group overwrites every lower word
  // position before it is written out, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (beat_fire) begin
      asm_q[WIDTH_STREAM * int'(beat_cnt_q) +: WIDTH_STREAM] <= S_Data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) rd_valid_q <= 1'b0;
    else      rd_valid_q <= scale_rd_en;
  end

  assign S_Ready          = (state_q == LOAD);
  assign load_done        = (state_q == DONE);
  assign busy             = (state_q != IDLE);
  assign scale_data_valid = rd_valid_q;

  // Group addresses wrap modulo the RAM depth when more groups are loaded.
  image_scale_ram u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (grp_cnt_q[WIDTH_GROUP_ADDR-1:0]),
    .wr_data (wr_data),
    .rd_en   (scale_rd_en),
    .rd_addr (scale_rd_group),
    .rd_data (scale_data)
  );

endmodule

// File: tb/tb_image_scale_param_buffer.sv
// Self-checking bench for image_scale_param_buffer: randomized loads checked
// against a group-array model filled from the stream rules.
module tb_image_scale_param_buffer;
  import image_scale_param_buffer_pkg::*;

  localparam int W = IMAGE_BIAS_WIDTH_DATA;

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic                        load_start = 1'b0;
  logic [WIDTH_GROUP_ADDR:0]   load_groups = '0;
  logic [WIDTH_STREAM-1:0]     S_Data = '0;
  logic                        S_Valid = 1'b0;
  logic                        S_Ready;
  logic                        load_done;
  logic                        busy;
  logic                        scale_rd_en = 1'b0;
  logic [WIDTH_GROUP_ADDR-1:0] scale_rd_group = '0;
  logic [W-1:0]                scale_data;
  logic                        scale_data_valid;

  int n_vec = 0;
  int n_bad = 0;

  logic [WIDTH_DATA_ADD-1:0] model_mem [GROUP_DEPTH][COMPUTE_CHANNEL_OUT_NUM];
  logic [WIDTH_STREAM-1:0]   beat_q [$];

  always #5 clk = ~clk;

  image_scale_param_buffer dut (
    .clk              (clk),
    .rst              (rst),
    .load_start       (load_start),
    .load_groups      (load_groups),
    .S_Data           (S_Data),
    .S_Valid          (S_Valid),
    .S_Ready          (S_Ready),
    .load_done        (load_done),
    .busy             (busy),
    .scale_rd_en      (scale_rd_en),
    .scale_rd_group   (scale_rd_group),
    .scale_data       (scale_data),
    .scale_data_valid (scale_data_valid)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] expect_group(input int g);
    logic [W-1:0] r;
    for (int j = 0; j < COMPUTE_CHANNEL_OUT_NUM; j++)
      r[j*WIDTH_DATA_ADD +: WIDTH_DATA_ADD] = model_mem[g][j];
    return r;
  endfunction

  // Loads ng groups. Beats come from beat_q when present, else random.
  // rd_on_last reads the final group together with its last beat and again
  // one cycle later; restart pulses load_start mid-load.
  task automatic run_load(input int ng, input int valid_pct, input bit toggle,
                          input bit rd_on_last, input bit restart);
    int beats;
    int sent;
    int cyc;
    int lg;
    bit v;
    bit coll;
    logic [WIDTH_STREAM-1:0]   d;
    logic [W-1:0]              old_grp;
    logic [WIDTH_DATA_ADD-1:0] asmw [COMPUTE_CHANNEL_OUT_NUM];
    beats = ng * BEATS_PER_GROUP;
    sent  = 0;
    cyc   = 0;
    lg    = (ng > 0) ? (ng - 1) % GROUP_DEPTH : 0;
    load_groups = (WIDTH_GROUP_ADDR + 1)'(ng);
    load_start  = 1'b1;
    tick();
    load_start = 1'b0;
    while (sent < beats && cyc < 4000) begin
      v = toggle ? (cyc % 2 == 0) : ($urandom_range(99) < valid_pct);
      if (v) d = (beat_q.size() > 0) ? beat_q.pop_front() : {$urandom, $urandom};
      else   d = {$urandom, $urandom};
      S_Valid = v;
      S_Data  = d;
      if (restart && cyc == 2) begin
        load_start  = 1'b1;
        load_groups = 7'd5;
      end
      coll = rd_on_last && v && (sent == beats - 1);
      if (coll) begin
        scale_rd_en    = 1'b1;
        scale_rd_group = WIDTH_GROUP_ADDR'(lg);
        old_grp        = expect_group(lg);
      end
      check("s_ready_load", S_Ready, 1);
      check("busy_load", busy, 1);
      check("load_done_early", load_done, 0);
      tick();
      load_start  = 1'b0;
      scale_rd_en = 1'b0;
      if (v) begin
        asmw[2*(sent % BEATS_PER_GROUP)]     = d[31:0];
        asmw[2*(sent % BEATS_PER_GROUP) + 1] = d[63:32];
        if (sent % BEATS_PER_GROUP == BEATS_PER_GROUP - 1)
          for (int j = 0; j < COMPUTE_CHANNEL_OUT_NUM; j++)
            model_mem[(sent / BEATS_PER_GROUP) % GROUP_DEPTH][j] = asmw[j];
        sent++;
      end
      if (coll) begin
        check("collide_old", scale_data, old_grp);
        check("collide_valid", scale_data_valid, 1);
      end
      cyc++;
    end
    if (sent < beats) check("load_timeout", sent, beats);
    S_Valid = 1'b0;
    check("load_done", load_done, 1);
    check("busy_in_done", busy, 1);
    check("s_ready_done", S_Ready, 0);
    if (rd_on_last) begin
      scale_rd_en    = 1'b1;
      scale_rd_group = WIDTH_GROUP_ADDR'(lg);
    end
    tick();
    scale_rd_en = 1'b0;
    if (rd_on_last) check("collide_new", scale_data, expect_group(lg));
    check("load_done_pulse", load_done, 0);
    check("busy_idle", busy, 0);
    check("s_ready_idle", S_Ready, 0);
    if (restart) begin
      repeat (8) begin
        tick();
        check("no_second_done", load_done, 0);
        check("busy_stays_low", busy, 0);
      end
    end
  endtask

  // Back-to-back reads of n groups starting at first, then one idle cycle.
  task automatic read_groups(input int first, input int n);
    int g;
    g = first;
    for (int i = 0; i < n; i++) begin
      g = (first + i) % GROUP_DEPTH;
      scale_rd_en    = 1'b1;
      scale_rd_group = WIDTH_GROUP_ADDR'(g);
      tick();
      check("rd_data", scale_data, expect_group(g));
      check("rd_valid", scale_data_valid, 1);
    end
    scale_rd_en = 1'b0;
    tick();
    check("rd_valid_pulse", scale_data_valid, 0);
    check("rd_data_hold", scale_data, expect_group(g));
  endtask

  initial begin
    repeat (3) tick();
    check("rst_s_ready", S_Ready, 0);
    check("rst_load_done", load_done, 0);
    check("rst_busy", busy, 0);
    check("rst_scale_data", scale_data, '0);
    check("rst_valid", scale_data_valid, 0);
    rst = 1'b1;
    tick();

    // Directed single group: words 1..8.
    beat_q.push_back(64'h00000002_00000001);
    beat_q.push_back(64'h00000004_00000003);
    beat_q.push_back(64'h00000006_00000005);
    beat_q.push_back(64'h00000008_00000007);
    run_load(1, 100, 1'b0, 1'b0, 1'b0);
    scale_rd_en    = 1'b1;
    scale_rd_group = '0;
    tick();
    scale_rd_en = 1'b0;
    check("directed_words",
          scale_data, 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
    check("directed_valid", scale_data_valid, 1);
    tick();
    check("directed_valid_drop", scale_data_valid, 0);

    // Three groups with S_Valid toggling every other cycle.
    run_load(3, 0, 1'b1, 1'b0, 1'b0);
    read_groups(0, 3);

    // Zero-group load: immediate done, no beats.
    run_load(0, 100, 1'b0, 1'b0, 1'b0);

    // Read/write collision on group 1.
    repeat (2 * BEATS_PER_GROUP) beat_q.push_back(64'hAAAAAAAA_AAAAAAAA);
    run_load(2, 100, 1'b0, 1'b0, 1'b0);
    repeat (2 * BEATS_PER_GROUP) beat_q.push_back(64'h55555555_55555555);
    run_load(2, 100, 1'b0, 1'b1, 1'b0);

    // Reset after two beats of a load.
    scale_rd_en    = 1'b1;
    scale_rd_group = 6'd1;
    tick();
    scale_rd_en = 1'b0;
    load_groups = 7'd1;
    load_start  = 1'b1;
    tick();
    load_start = 1'b0;
    S_Valid    = 1'b1;
    S_Data     = {$urandom, $urandom};
    tick();
    S_Data = {$urandom, $urandom};
    tick();
    S_Valid = 1'b0;
    rst     = 1'b0;
    tick();
    check("mid_rst_s_ready", S_Ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", load_done, 0);
    check("mid_rst_scale_data", scale_data, '0);
    rst = 1'b1;
    repeat (3) begin
      tick();
      check("mid_rst_no_done", load_done, 0);
    end
    read_groups(1, 1);
    run_load(1, 100, 1'b0, 1'b0, 1'b0);
    read_groups(0, 2);

    // load_start during LOAD is ignored.
    run_load(2, 100, 1'b0, 1'b0, 1'b1);
    read_groups(0, 2);

    // Random loads with random stream gaps.
    for (int k = 0; k < 4; k++) begin
      run_load(int'($urandom_range(1, 6)), int'($urandom_range(30, 100)), 1'b0, 1'b0, 1'b0);
      read_groups(0, 6);
    end

    // More groups than capacity: addresses wrap.
    run_load(GROUP_DEPTH + 2, 70, 1'b0, 1'b0, 1'b0);
    read_groups(0, GROUP_DEPTH);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
